sigmeas: RTL and testbench
==========================

SIGMEAS -- requirements
Module: sigmeas

Interface
REQ-001 SHALL have parameter _RAM_WIDTH, default 32, width of all counters and width/limit ports.
REQ-002 SHALL have port io_clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port io_rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port io_sigIn  input  1  pulse to measure; asynchronous to io_clk.
REQ-005 SHALL have port io_activeLevel  input  1  pulse polarity: 1 = high pulse, 0 = low pulse.
REQ-006 SHALL have port io_maxWidth  input  _RAM_WIDTH  overflow limit in clocks; 0 means 2^_RAM_WIDTH-1.
REQ-007 SHALL have port io_arm  input  1  one-cycle request to start a single-shot measurement.
REQ-008 SHALL have port io_abort  input  1  level; cancels measurement, holds block idle.
REQ-009 SHALL have port io_width  output  _RAM_WIDTH  last measured width in io_clk cycles.
REQ-010 SHALL have port io_valid  output  1  one-cycle strobe; io_width/io_ovf updated this cycle.
REQ-011 SHALL have port io_ovf  output  1  last result hit the limit.
REQ-012 SHALL have port io_busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL pass io_sigIn through two flops (sync), then one more flop (prev); act = (sync == latched polarity), act_prev likewise.
REQ-014 SHALL define start edge = act & ~act_prev; end edge = ~act & act_prev.
REQ-015 SHALL implement states IDLE, WAIT_START, MEASURE.
REQ-016 IDLE: io_arm=1 and io_abort=0 -> latch io_activeLevel and io_maxWidth, go WAIT_START; io_arm ignored in other states.
REQ-017 WAIT_START: start edge -> cnt <= 1, go MEASURE; a signal already active at arm SHALL NOT start a measurement (fresh edge required).
REQ-018 MEASURE, act=1: if cnt == limit -> io_width <= limit, io_ovf <= 1, io_valid pulse, go IDLE; else cnt <= cnt+1.
REQ-019 MEASURE, end edge: io_width <= cnt, io_ovf <= 0, io_valid pulse, go IDLE.
REQ-020 Width SHALL equal number of io_clk cycles the synchronized signal was active; pulse of exactly limit cycles -> width=limit, ovf=0; limit+1 -> ovf=1.
REQ-021 io_valid SHALL be registered, asserted the cycle after the end-edge/limit detection cycle, with io_width/io_ovf updated the same cycle and io_busy already low.
REQ-022 io_width and io_ovf SHALL hold until the next io_valid.
REQ-023 io_abort SHALL have highest priority: any state -> IDLE next cycle, no io_valid, io_width/io_ovf unchanged; arm+abort same cycle -> stay IDLE.
REQ-024 Changes to io_activeLevel/io_maxWidth while busy SHALL NOT affect the current measurement.
REQ-025 cnt SHALL never wrap; limit check precedes increment.

Reset
REQ-026 io_rst SHALL force state IDLE, cnt=0, sync/prev flops=0, io_width=0, io_ovf=0, io_valid=0, io_busy=0.
REQ-027 Reset mid-measurement SHALL discard it with no io_valid; after release, first start requires new io_arm.

Structure
REQ-028 State encoding constants and default _RAM_WIDTH SHALL reside in shared package rf_pwm_pkg.
REQ-029 Synchronizer plus edge detect SHALL be a sub-module sig_sync_edge (outputs act, start, end).
REQ-030 Implementation SHALL be 120-400 RTL lines, single clock domain after sync.

Verification
REQ-031 Arm, polarity 1, limit 0, drive 100-cycle high pulse -> one io_valid, io_width=100, io_ovf=0, busy low after.
REQ-032 Polarity 0, 1-cycle low pulse (aligned to clock) -> io_width=1, io_ovf=0.
REQ-033 Limit 50, 51-cycle pulse -> io_width=50, io_ovf=1; 50-cycle pulse -> io_width=50, io_ovf=0.
REQ-034 io_sigIn already high at arm, falls, rises for 20 cycles -> only the 20-cycle pulse reported, io_width=20.
REQ-035 io_abort after 10 cycles of a 100-cycle pulse -> no io_valid, previous io_width retained; io_rst mid-pulse -> all outputs 0.
REQ-036 Loopback from sigpulse with io_pulseWidth=N (N=1,7,1000), matching polarity -> io_width=N.

Source files
------------

// File: rtl/rf_pwm_pkg.sv
// -----------------------------------------------------------------------------
// rf_pwm_pkg
//   Shared definitions for the pulse-measurement blocks.
//   - DEFAULT_RAM_WIDTH : default width of counters and width/limit ports
//   - state_t           : measurement controller state encoding
// -----------------------------------------------------------------------------
package rf_pwm_pkg;

  localparam int DEFAULT_RAM_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_MEASURE    = 2'd2
  } state_t;

endpackage

// File: rtl/sig_sync_edge.sv
// -----------------------------------------------------------------------------
// sig_sync_edge
//   Two-flop synchronizer for an asynchronous input, one extra history flop,
//   and polarity-aware activity / edge detection.
//
//   Ports
//     io_clk    in  system clock, rising edge
//     io_rst    in  asynchronous active-high reset (clears all flops)
//     sig_in    in  raw asynchronous signal
//     pol       in  active polarity (1 = high is active, 0 = low is active)
//     act       out synchronized signal currently at the active level
//     start     out synchronized signal just became active
//     end_edge  out synchronized signal just became inactive
// -----------------------------------------------------------------------------
module sig_sync_edge (
  input  logic io_clk,
  input  logic io_rst,
  input  logic sig_in,
  input  logic pol,
  output logic act,
  output logic start,
  output logic end_edge
);

  logic sync_meta;
  logic sync_q;
  logic prev_q;
  logic act_prev;

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      sync_meta <= sig_in;
      sync_q    <= sync_meta;
      prev_q    <= sync_q;
    end
  end

  // Both activity terms use the same polarity, so a polarity change alone
  // can never fabricate an edge: only a real transition of the synchronized
  // signal makes act and act_prev differ.
  assign act      = (sync_q == pol);
  assign act_prev = (prev_q == pol);
  assign start    = act & ~act_prev;
  assign end_edge = ~act & act_prev;

endmodule

// File: rtl/sigmeas.sv
// -----------------------------------------------------------------------------
// sigmeas
//   Single-shot pulse-width meter. After an arm request it waits for a fresh
//   active edge on io_sigIn, counts io_clk cycles while the synchronized
//   signal stays active, and reports the width (saturating at a limit).
//
//   Handshake: io_arm is a one-cycle request accepted only while idle
//   (io_busy low); there is no ready/backpressure on the result side --
//   io_valid is a one-cycle strobe and io_width/io_ovf change only on that
//   cycle, holding until the next strobe. io_abort is a level that wins over
//   everything and returns the block to idle without a result.
//
//   Ports
//     io_clk          in  system clock, rising edge
//     io_rst          in  asynchronous active-high reset
//     io_sigIn        in  pulse to measure (asynchronous)
//     io_activeLevel  in  pulse polarity, latched at arm
//     io_maxWidth     in  overflow limit in clocks, 0 = all ones; latched at arm
//     io_arm          in  start request
//     io_abort        in  cancel / hold idle
//     io_width        out last measured width
//     io_valid        out result strobe
//     io_ovf          out last result hit the limit
//     io_busy         out not idle
//     state_dbg       out current controller state (observation only)
// -----------------------------------------------------------------------------
module sigmeas
  import rf_pwm_pkg::*;
#(
  parameter int _RAM_WIDTH = DEFAULT_RAM_WIDTH
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  io_sigIn,
  input  logic                  io_activeLevel,
  input  logic [_RAM_WIDTH-1:0] io_maxWidth,
  input  logic                  io_arm,
  input  logic                  io_abort,
  output logic [_RAM_WIDTH-1:0] io_width,
  output logic                  io_valid,
  output logic                  io_ovf,
  output logic                  io_busy,
  output state_t                state_dbg
);

  localparam int W = _RAM_WIDTH;

  state_t       state;
  logic         pol;
  logic [W-1:0] limit;
  logic [W-1:0] cnt;

  logic act;
  logic start;
  logic end_edge;

  sig_sync_edge u_sync (
    .io_clk   (io_clk),
    .io_rst   (io_rst),
    .sig_in   (io_sigIn),
    .pol      (pol),
    .act      (act),
    .start    (start),
    .end_edge (end_edge)
  );

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state    <= ST_IDLE;
      pol      <= 1'b0;
      limit    <= '1;
      cnt      <= '0;
      io_width <= '0;
      io_ovf   <= 1'b0;
      io_valid <= 1'b0;
      io_busy  <= 1'b0;
    end else begin
      io_valid <= 1'b0;
      if (io_abort) begin
        state   <= ST_IDLE;
        io_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (io_arm) begin
              // Polarity and limit are captured here so later input changes
              // cannot disturb a measurement in progress.
              pol     <= io_activeLevel;
              limit   <= (io_maxWidth == '0) ? '1 : io_maxWidth;
              state   <= ST_WAIT_START;
              io_busy <= 1'b1;
            end
          end

          ST_WAIT_START: begin
            // A signal already active at arm has no start edge, so it is
            // skipped until it goes inactive and returns.
            if (start) begin
              cnt   <= W'(1);
              state <= ST_MEASURE;
            end
          end

          ST_MEASURE: begin
            if (act) begin
              // Limit check before increment: cnt saturates, never wraps.
              if (cnt == limit) begin
                io_width <= limit;
                io_ovf   <= 1'b1;
                io_valid <= 1'b1;
                state    <= ST_IDLE;
                io_busy  <= 1'b0;
              end else begin
                cnt <= cnt + W'(1);
              end
            end else if (end_edge) begin
              io_width <= cnt;
              io_ovf   <= 1'b0;
              io_valid <= 1'b1;
              state    <= ST_IDLE;
              io_busy  <= 1'b0;
            end
          end

          default: begin
            state   <= ST_IDLE;
            io_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sigmeas.sv
module tb_sigmeas;
  import rf_pwm_pkg::*;

  localparam int W = 32;

  // ---------------------------------------------------------------- clock/reset
  logic         io_clk = 1'b0;
  logic         io_rst;
  logic         io_sigIn;
  logic         io_activeLevel;
  logic [W-1:0] io_maxWidth;
  logic         io_arm;
  logic         io_abort;
  logic [W-1:0] io_width;
  logic         io_valid;
  logic         io_ovf;
  logic         io_busy;
  state_t       state_dbg;

  always #5 io_clk = ~io_clk;

  sigmeas #(._RAM_WIDTH(W)) dut (
    .io_clk         (io_clk),
    .io_rst         (io_rst),
    .io_sigIn       (io_sigIn),
    .io_activeLevel (io_activeLevel),
    .io_maxWidth    (io_maxWidth),
    .io_arm         (io_arm),
    .io_abort       (io_abort),
    .io_width       (io_width),
    .io_valid       (io_valid),
    .io_ovf         (io_ovf),
    .io_busy        (io_busy),
    .state_dbg      (state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W:0]   exp_q[$];     // {ovf, width}
  logic [W:0]   mon_e;
  logic [W-1:0] last_w   = '0;
  logic         last_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the synchronized pulse lasts exactly n clocks; the reported
  // width is n clipped to the effective limit, ovf when n exceeds it.
  function automatic void expect_pulse(input int unsigned n, input logic [W-1:0] maxw);
    longint unsigned lim;
    longint unsigned w;
    logic            o;
    lim = (maxw == '0) ? ((64'd1 << W) - 1) : longint'(maxw);
    o   = (longint'(n) > lim);
    w   = o ? lim : longint'(n);
    exp_q.push_back({o, w[W-1:0]});
    last_w   = w[W-1:0];
    last_ovf = o;
  endfunction

  always @(negedge io_clk) begin
    if (!io_rst && io_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("width", io_width, mon_e[W-1:0]);
        check("ovf", io_ovf, mon_e[W]);
      end
      check("busy_at_valid", io_busy, 0);
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic cyc(input int n);
    repeat (n) @(negedge io_clk);
  endtask

  task automatic arm(input logic pol, input logic [W-1:0] maxw);
    io_activeLevel = pol;
    io_maxWidth    = maxw;
    io_arm         = 1'b1;
    cyc(1);
    io_arm = 1'b0;
    check("busy_after_arm", io_busy, 1);
  endtask

  task automatic finish_case(input string tag);
    check({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, "_busy_idle"}, io_busy, 0);
  endtask

  // Arm, scramble the live configuration inputs, then drive an aligned pulse.
  task automatic measure(input logic pol, input logic [W-1:0] maxw, input int unsigned n);
    io_sigIn = ~pol;
    cyc(4);
    arm(pol, maxw);
    io_activeLevel = 1'($urandom_range(0, 1));
    io_maxWidth    = $urandom;
    expect_pulse(n, maxw);
    io_sigIn = pol;
    cyc(int'(n));
    io_sigIn = ~pol;
    cyc(8);
    finish_case("measure");
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    io_rst = 1'b1; io_sigIn = 1'b0; io_activeLevel = 1'b1; io_maxWidth = '0;
    io_arm = 1'b0; io_abort = 1'b0;
    cyc(3);
    check("rst_width", io_width, 0);
    check("rst_ovf", io_ovf, 0);
    check("rst_valid", io_valid, 0);
    check("rst_busy", io_busy, 0);
    io_rst = 1'b0;
    cyc(2);

    // directed widths, limits and polarities
    measure(1'b1, '0, 100);
    measure(1'b0, '0, 1);
    measure(1'b1, W'(50), 51);
    measure(1'b1, W'(50), 50);
    measure(1'b1, '0, 1);
    measure(1'b1, '0, 7);
    measure(1'b1, '0, 1000);
    measure(1'b0, W'(3), 200);
    measure(1'b0, W'(1), 1);
    measure(1'b1, W'(1), 2);

    // signal already active at arm: only the later fresh pulse counts
    io_sigIn = 1'b1;
    cyc(4);
    arm(1'b1, '0);
    cyc(10);
    io_sigIn = 1'b0;
    cyc(5);
    expect_pulse(20, '0);
    io_sigIn = 1'b1;
    cyc(20);
    io_sigIn = 1'b0;
    cyc(8);
    finish_case("pre_active");

    // abort mid-pulse: no result, previous result retained
    io_sigIn = 1'b0;
    cyc(4);
    arm(1'b1, '0);
    io_sigIn = 1'b1;
    cyc(10);
    io_abort = 1'b1;
    cyc(1);
    io_abort = 1'b0;
    check("abort_busy", io_busy, 0);
    cyc(90);
    io_sigIn = 1'b0;
    cyc(8);
    check("abort_width_kept", io_width, last_w);
    check("abort_ovf_kept", io_ovf, last_ovf);
    finish_case("abort");

    // arm and abort together: stays idle
    io_arm = 1'b1; io_abort = 1'b1;
    cyc(1);
    io_arm = 1'b0; io_abort = 1'b0;
    check("arm_abort_busy", io_busy, 0);
    io_sigIn = 1'b1;
    cyc(5);
    io_sigIn = 1'b0;
    cyc(8);
    finish_case("arm_abort");

    // random measurements against the model
    for (int i = 0; i < 25; i++) begin
      logic         p;
      logic [W-1:0] m;
      int unsigned  n;
      p = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(1, 40));
      n = $urandom_range(1, 60);
      measure(p, m, n);
    end

    // reset mid-pulse: outputs cleared, no result, no restart without arm
    io_sigIn = 1'b0;
    cyc(4);
    arm(1'b1, '0);
    io_sigIn = 1'b1;
    cyc(10);
    #2 io_rst = 1'b1;
    #1;
    check("midrst_width", io_width, 0);
    check("midrst_ovf", io_ovf, 0);
    check("midrst_valid", io_valid, 0);
    check("midrst_busy", io_busy, 0);
    cyc(2);
    io_rst = 1'b0;
    last_w = '0; last_ovf = 1'b0;
    cyc(20);
    io_sigIn = 1'b0;
    cyc(4);
    io_sigIn = 1'b1;
    cyc(10);
    io_sigIn = 1'b0;
    cyc(8);
    check("post_rst_width", io_width, last_w);
    finish_case("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
